// File: rtl/tdm_demux2_if.sv
// Serial-in / parallel-out bundle between a TDM line source and tdm_demux2.
// master drives the serial line and frame sync; slave returns the channel words.
interface tdm_demux2_if #(
    parameter int unsigned WIDTH = 4
);
    logic             d;
    logic             sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_valid;
    logic             b_valid;
    logic             s;
    logic             busy;
    logic             err;

    modport master (
        output d, sync,
        input  a, b, a_valid, b_valid, s, busy, err
    );

    modport slave (
        input  d, sync,
        output a, b, a_valid, b_valid, s, busy, err
    );
endinterface

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: splits an alternating A/B serial line into two
// parallel channel words, each flagged by a one-cycle valid strobe.
module tdm_demux2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux2_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StChA, StChB} state_e;

    state_e           state;
    logic [CntW-1:0]  cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] first_bit;

    always_comb begin
        shift_in  = (shreg << 1) | WIDTH'(bus.d);
        first_bit = WIDTH'(bus.d);
    end

    // cnt holds the number of bits already taken in the current slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            cnt         <= '0;
            shreg       <= '0;
            bus.a       <= '0;
            bus.b       <= '0;
            bus.a_valid <= 1'b0;
            bus.b_valid <= 1'b0;
            bus.s       <= 1'b0;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.a_valid <= 1'b0;
            bus.b_valid <= 1'b0;
            bus.err     <= 1'b0;
            if (bus.sync) begin
                // Any sync restarts the frame; only one outside IDLE is an error.
                bus.err  <= (state != StIdle);
                shreg    <= first_bit;
                bus.busy <= 1'b1;
                if (WIDTH == 1) begin
                    bus.a       <= first_bit;
                    bus.a_valid <= 1'b1;
                    cnt         <= '0;
                    state       <= StChB;
                    bus.s       <= 1'b1;
                end else begin
                    cnt   <= CntW'(1);
                    state <= StChA;
                    bus.s <= 1'b0;
                end
            end else begin
                case (state)
                    StChA: begin
                        shreg <= shift_in;
                        if (cnt == LastCnt) begin
                            bus.a       <= shift_in;
                            bus.a_valid <= 1'b1;
                            cnt         <= '0;
                            state       <= StChB;
                            bus.s       <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StChB: begin
                        shreg <= shift_in;
                        if (cnt == LastCnt) begin
                            bus.b       <= shift_in;
                            bus.b_valid <= 1'b1;
                            cnt         <= '0;
                            state       <= StIdle;
                            bus.s       <= 1'b0;
                            bus.busy    <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux2.sv
// Bench for tdm_demux2: WIDTH=4 and WIDTH=1 instances checked every cycle against
// a frame-position reference model, directed scenarios followed by random traffic.
module tb_tdm_demux2;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tdm_demux2_if #(.WIDTH(4)) bus0 ();
    tdm_demux2_if #(.WIDTH(1)) bus1 ();

    tdm_demux2 #(.WIDTH(4)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    tdm_demux2 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: per instance, how many bits of the current frame were taken.
    int wd [2] = '{4, 1};
    bit act [2];
    int pos [2];
    bit bits [2][32];
    int e_a [2];
    int e_b [2];
    bit e_av [2];
    bit e_bv [2];
    bit e_s [2];
    bit e_busy [2];
    bit e_err [2];
    bit ph1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pack(input int i, input int base);
        int v = 0;
        for (int j = 0; j < wd[i]; j++) v = v * 2 + int'(bits[i][base + j]);
        return v;
    endfunction

    task automatic model_step(input int i, input bit r, input bit sy, input bit dd);
        e_av[i]  = 1'b0;
        e_bv[i]  = 1'b0;
        e_err[i] = 1'b0;
        if (r) begin
            act[i] = 1'b0;
            pos[i] = 0;
            e_a[i] = 0;
            e_b[i] = 0;
        end else begin
            if (sy) begin
                if (act[i]) e_err[i] = 1'b1;
                act[i] = 1'b1;
                pos[i] = 0;
            end
            if (act[i]) begin
                bits[i][pos[i]] = dd;
                pos[i]++;
                if (pos[i] == wd[i]) begin
                    e_a[i]  = pack(i, 0);
                    e_av[i] = 1'b1;
                end
                if (pos[i] == 2 * wd[i]) begin
                    e_b[i]  = pack(i, wd[i]);
                    e_bv[i] = 1'b1;
                    act[i]  = 1'b0;
                end
            end
        end
        e_busy[i] = act[i];
        e_s[i]    = act[i] && (pos[i] >= wd[i]);
    endtask

    task automatic compare_dut(input int i, input logic [31:0] a, input logic [31:0] b,
                               input logic av, input logic bv, input logic s,
                               input logic busy, input logic err);
        check_eq($sformatf("d%0d_a", i), a, 32'(e_a[i]));
        check_eq($sformatf("d%0d_b", i), b, 32'(e_b[i]));
        check_eq($sformatf("d%0d_a_valid", i), 32'(av), 32'(e_av[i]));
        check_eq($sformatf("d%0d_b_valid", i), 32'(bv), 32'(e_bv[i]));
        check_eq($sformatf("d%0d_s", i), 32'(s), 32'(e_s[i]));
        check_eq($sformatf("d%0d_busy", i), 32'(busy), 32'(e_busy[i]));
        check_eq($sformatf("d%0d_err", i), 32'(err), 32'(e_err[i]));
    endtask

    task automatic step(input bit r, input bit sy0, input bit dd0, input bit sy1, input bit dd1);
        rst       = r;
        bus0.sync = sy0;
        bus0.d    = dd0;
        bus1.sync = sy1;
        bus1.d    = dd1;
        model_step(0, r, sy0, dd0);
        model_step(1, r, sy1, dd1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_dut(0, 32'(bus0.a), 32'(bus0.b), bus0.a_valid, bus0.b_valid, bus0.s,
                    bus0.busy, bus0.err);
        compare_dut(1, 32'(bus1.a), 32'(bus1.b), bus1.a_valid, bus1.b_valid, bus1.s,
                    bus1.busy, bus1.err);
    endtask

    // Directed step for the WIDTH=4 instance; WIDTH=1 sees sync every 2 cycles, A=1, B=0.
    task automatic run0(input bit r, input bit sy, input bit dd);
        bit sy1;
        if (r) begin
            ph1 = 1'b0;
            sy1 = 1'b0;
        end else begin
            sy1 = ~ph1;
            ph1 = ~ph1;
        end
        step(r, sy, dd, sy1, sy1);
    endtask

    initial begin
        bit [7:0] f1;
        bit [7:0] f2;
        rst       = 1'b1;
        bus0.sync = 1'b0;
        bus0.d    = 1'b0;
        bus1.sync = 1'b0;
        bus1.d    = 1'b0;
        f1 = 8'b1011_0110;
        f2 = 8'b0001_1111;

        run0(1'b1, 1'b0, 1'b0);
        run0(1'b1, 1'b0, 1'b0);

        for (int j = 0; j < 8; j++) run0(1'b0, j == 0, f1[7 - j]);
        // Back-to-back: next sync lands in the b_valid cycle.
        run0(1'b0, 1'b1, f2[7]);
        check_eq("plan_frame1_a", 32'(bus0.a), 32'h0000_000B);
        check_eq("plan_frame1_b", 32'(bus0.b), 32'h0000_0006);
        for (int j = 1; j < 8; j++) run0(1'b0, 1'b0, f2[7 - j]);
        run0(1'b0, 1'b0, 1'b0);
        check_eq("plan_frame2_a", 32'(bus0.a), 32'h0000_0001);
        check_eq("plan_frame2_b", 32'(bus0.b), 32'h0000_000F);
        for (int j = 0; j < 3; j++) run0(1'b0, 1'b0, 1'($urandom));

        // Sync during channel B: partial word dropped, b must hold.
        for (int j = 0; j < 12; j++) run0(1'b0, (j == 0) || (j == 6), 1'($urandom));
        check_eq("plan_mid_b_hold", 32'(bus0.b), 32'h0000_000F);
        for (int j = 0; j < 6; j++) run0(1'b0, 1'b0, 1'($urandom));

        // Reset mid-frame, then a toggling line with no sync.
        for (int j = 0; j < 3; j++) run0(1'b0, j == 0, 1'($urandom));
        run0(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 10; j++) run0(1'b0, 1'b0, 1'(j % 2));
        check_eq("plan_rst_a", 32'(bus0.a), 32'h0);
        check_eq("plan_rst_b", 32'(bus0.b), 32'h0);

        for (int j = 0; j < 50; j++) run0(1'b0, 1'b0, 1'($urandom));
        check_eq("plan_w1_a", 32'(bus1.a), 32'h1);
        check_eq("plan_w1_b", 32'(bus1.b), 32'h0);

        for (int j = 0; j < 1500; j++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom),
                 $urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
